// File: rtl/cnt4b_disp_scan.sv
// Two-digit multiplexed 7-segment display stage for a 4-bit count (0..15).
// Latches the count once per frame and scans units then tens, each slot led by a blank cycle.
module cnt4b_disp_scan #(
    parameter int SCAN_DIV = 4,
    parameter bit BLANK_LZ = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [3:0] IN,
    output logic [6:0] SEG,
    output logic [1:0] DIG,
    output logic       CHG
);

    localparam int PW = $clog2(SCAN_DIV);
    localparam logic [PW-1:0] PLAST = PW'(SCAN_DIV - 1);

    typedef enum logic [1:0] {IDLE, UNITS, TENS} state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   pcnt_q, pcnt_d;
    logic [3:0]      frame_q, frame_d;
    logic [3:0]      prev_q, prev_d;
    logic            latch;
    logic            tens;
    logic [3:0]      units;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'h3F;
            4'd1:    seg7 = 7'h06;
            4'd2:    seg7 = 7'h5B;
            4'd3:    seg7 = 7'h4F;
            4'd4:    seg7 = 7'h66;
            4'd5:    seg7 = 7'h6D;
            4'd6:    seg7 = 7'h7D;
            4'd7:    seg7 = 7'h07;
            4'd8:    seg7 = 7'h7F;
            4'd9:    seg7 = 7'h6F;
            default: seg7 = 7'h00;
        endcase
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            pcnt_q  <= '0;
            frame_q <= '0;
            prev_q  <= '0;
        end else begin
            state_q <= state_d;
            pcnt_q  <= pcnt_d;
            frame_q <= frame_d;
            prev_q  <= prev_d;
        end
    end

    // en=0 always wins over a pending latch edge.
    always_comb begin
        state_d = state_q;
        pcnt_d  = pcnt_q;
        latch   = 1'b0;
        case (state_q)
            IDLE: begin
                if (en) begin
                    state_d = UNITS;
                    pcnt_d  = '0;
                    latch   = 1'b1;
                end
            end
            UNITS, TENS: begin
                if (!en) begin
                    state_d = IDLE;
                    pcnt_d  = '0;
                end else if (pcnt_q == PLAST) begin
                    pcnt_d  = '0;
                    state_d = (state_q == UNITS) ? TENS : UNITS;
                    latch   = (state_q == TENS);
                end else begin
                    pcnt_d  = pcnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                pcnt_d  = '0;
            end
        endcase
        frame_d = latch ? IN : frame_q;
        prev_d  = latch ? frame_q : prev_q;
    end

    assign tens  = (frame_q >= 4'd10);
    assign units = tens ? (frame_q - 4'd10) : frame_q;

    // UNITS at pcnt=0 is only ever reached through a latch edge, so the
    // frame/prev comparison there is exactly the change flag for that frame.
    always_comb begin
        SEG = 7'h00;
        DIG = 2'b00;
        CHG = (state_q == UNITS) && (pcnt_q == '0) && (frame_q != prev_q);
        if (pcnt_q != '0) begin
            if (state_q == UNITS) begin
                DIG = 2'b01;
                SEG = seg7(units);
            end else if (state_q == TENS && (tens || !BLANK_LZ)) begin
                DIG = 2'b10;
                SEG = seg7({3'b000, tens});
            end
        end
    end

endmodule

// File: tb/tb_cnt4b_disp_scan.sv
// Scoreboard bench for cnt4b_disp_scan: expected {SEG,DIG,CHG} per cycle queued, then popped after each edge.
module tb_cnt4b_disp_scan;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en  = 1'b0;
    logic [3:0] IN  = 4'd0;
    logic [6:0] SEG, SEG0;
    logic [1:0] DIG, DIG0;
    logic       CHG, CHG0;

    int n_cmp = 0;
    int n_mis = 0;
    logic [9:0] exp_q[$];
    logic [9:0] e;

    cnt4b_disp_scan #(.SCAN_DIV(4), .BLANK_LZ(1'b1)) dut (
        .clk(clk), .rst(rst), .en(en), .IN(IN), .SEG(SEG), .DIG(DIG), .CHG(CHG));
    cnt4b_disp_scan #(.SCAN_DIV(4), .BLANK_LZ(1'b0)) dut0 (
        .clk(clk), .rst(rst), .en(en), .IN(IN), .SEG(SEG0), .DIG(DIG0), .CHG(CHG0));

    always #5 clk = ~clk;

    function automatic logic [6:0] pat(input int d);
        logic [6:0] t [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                               7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
        return t[d];
    endfunction

    task automatic push_blank(input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(10'b0);
    endtask

    // One 8-cycle frame: units blank (carries CHG), 3 units, tens blank, 3 tens.
    task automatic push_frame(input int v, input bit chg, input bit blz);
        int u;
        u = (v >= 10) ? v - 10 : v;
        exp_q.push_back({7'h00, 2'b00, chg});
        for (int i = 0; i < 3; i++) exp_q.push_back({pat(u), 2'b01, 1'b0});
        exp_q.push_back(10'b0);
        for (int i = 0; i < 3; i++) begin
            if (v >= 10)  exp_q.push_back({7'h06, 2'b10, 1'b0});
            else if (blz) exp_q.push_back(10'b0);
            else          exp_q.push_back({7'h3F, 2'b10, 1'b0});
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; en = 1'b1; IN = 4'd9;
        push_blank(3);
        for (int i = 0; i < 3; i++) begin
            step();
            e = exp_q.pop_front();
            n_cmp++;
            if ({SEG, DIG, CHG} !== e) begin
                n_mis++;
                $display("FAIL reset cyc%0d: got %h/%b/%b want %h/%b/%b", i, SEG, DIG, CHG, e[9:3], e[2:1], e[0]);
            end
        end
        #2 rst = 1'b1;
    endtask

    task automatic test_units_only();
        push_frame(9, 1'b1, 1'b1);
        push_frame(9, 1'b0, 1'b1);
        push_frame(9, 1'b0, 1'b1);
        for (int i = 0; i < 24; i++) begin
            step();
            e = exp_q.pop_front();
            n_cmp++;
            if ({SEG, DIG, CHG} !== e) begin
                n_mis++;
                $display("FAIL in9 cyc%0d: got %h/%b/%b want %h/%b/%b", i, SEG, DIG, CHG, e[9:3], e[2:1], e[0]);
            end
        end
    endtask

    task automatic test_in_change();
        push_frame(9, 1'b0, 1'b1);
        push_frame(14, 1'b1, 1'b1);
        push_frame(14, 1'b0, 1'b1);
        for (int i = 0; i < 24; i++) begin
            step();
            if (i == 6) IN = 4'd14;
            e = exp_q.pop_front();
            n_cmp++;
            if ({SEG, DIG, CHG} !== e) begin
                n_mis++;
                $display("FAIL in9to14 cyc%0d: got %h/%b/%b want %h/%b/%b", i, SEG, DIG, CHG, e[9:3], e[2:1], e[0]);
            end
        end
    endtask

    task automatic test_en_drop();
        exp_q.push_back(10'b0);
        exp_q.push_back({7'h66, 2'b01, 1'b0});
        exp_q.push_back({7'h66, 2'b01, 1'b0});
        push_blank(3);
        push_frame(14, 1'b0, 1'b1);
        push_blank(2);
        push_frame(14, 1'b0, 1'b1);
        for (int i = 0; i < 24; i++) begin
            step();
            if (i == 2)  en = 1'b0;
            if (i == 5)  en = 1'b1;
            // drop en right on the latch edge with a new IN: no latch must happen
            if (i == 13) begin en = 1'b0; IN = 4'd5; end
            if (i == 15) begin en = 1'b1; IN = 4'd14; end
            e = exp_q.pop_front();
            n_cmp++;
            if ({SEG, DIG, CHG} !== e) begin
                n_mis++;
                $display("FAIL endrop cyc%0d: got %h/%b/%b want %h/%b/%b", i, SEG, DIG, CHG, e[9:3], e[2:1], e[0]);
            end
        end
    endtask

    task automatic test_async_reset();
        step();
        step();
        #2 rst = 1'b0;
        #1;
        n_cmp++;
        if ({SEG, DIG, CHG} !== 10'b0) begin
            n_mis++;
            $display("FAIL async_rst: got %h/%b/%b want 00/00/0", SEG, DIG, CHG);
        end
        step();
        IN = 4'd15;
        #2 rst = 1'b1;
    endtask

    task automatic test_in15();
        push_frame(15, 1'b1, 1'b1);
        push_frame(15, 1'b0, 1'b1);
        for (int i = 0; i < 16; i++) begin
            step();
            e = exp_q.pop_front();
            n_cmp++;
            if ({SEG, DIG, CHG} !== e) begin
                n_mis++;
                $display("FAIL in15 cyc%0d: got %h/%b/%b want %h/%b/%b", i, SEG, DIG, CHG, e[9:3], e[2:1], e[0]);
            end
        end
    endtask

    task automatic test_blank_lz0();
        rst = 1'b0; IN = 4'd0;
        step();
        #2 rst = 1'b1;
        push_frame(0, 1'b0, 1'b0);
        push_frame(0, 1'b0, 1'b0);
        for (int i = 0; i < 16; i++) begin
            step();
            e = exp_q.pop_front();
            n_cmp++;
            if ({SEG0, DIG0, CHG0} !== e) begin
                n_mis++;
                $display("FAIL lz0 cyc%0d: got %h/%b/%b want %h/%b/%b", i, SEG0, DIG0, CHG0, e[9:3], e[2:1], e[0]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_units_only();
        test_in_change();
        test_en_drop();
        test_async_reset();
        test_in15();
        test_blank_lz0();
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_mis++;
            $display("FAIL scoreboard_leftover: got %0d entries want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
